// File: rtl/operand_forward_unit.sv
// EX-stage ALU source selector: tracks destination tags of the instructions ahead of EX,
// forwards the youngest matching result, and requests a one-cycle stall on load-use.
module operand_forward_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int STAGES   = 2,
    parameter int ALU_OP_W = 4,
    parameter int STG_W    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_hold,
    input  logic                     ex_valid,
    input  logic                     ex_src_used,
    input  logic [ADDR_W-1:0]        ex_src_addr,
    input  logic [ADDR_W-1:0]        ex_dst_addr,
    input  logic                     ex_wb_en,
    input  logic                     ex_is_load,
    input  logic                     ex_imm,
    input  logic [ALU_OP_W-1:0]      ex_alu_op,
    input  logic [DATA_W-1:0]        immediate,
    input  logic                     in_port_sig,
    input  logic [DATA_W-1:0]        in_port_data,
    input  logic [DATA_W-1:0]        rf_data,
    input  logic [STAGES*DATA_W-1:0] stage_data,
    output logic [DATA_W-1:0]        operand,
    output logic [1:0]               src_kind,
    output logic [STG_W-1:0]         fwd_stage,
    output logic                     stall,
    output logic [15:0]              fwd_cnt,
    output logic [15:0]              stall_cnt
);

    localparam logic [1:0] KIND_RF   = 2'b00;
    localparam logic [1:0] KIND_FWD  = 2'b01;
    localparam logic [1:0] KIND_IMM  = 2'b10;
    localparam logic [1:0] KIND_PORT = 2'b11;

    localparam logic [ALU_OP_W-1:0] OP_IMM_ELSEWHERE_A = ALU_OP_W'(4'b1011);
    localparam logic [ALU_OP_W-1:0] OP_IMM_ELSEWHERE_B = ALU_OP_W'(4'b1100);

    // Tag k describes the producer whose result is on stage_data slice k.
    logic [STAGES-1:0] tag_valid_q;
    logic [STAGES-1:0] tag_load_q;
    logic [ADDR_W-1:0] tag_addr_q [STAGES];

    logic [15:0] fwd_cnt_q, fwd_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic              imm_sel;
    logic [STAGES-1:0] match;
    logic              fwd_hit;
    logic [STG_W-1:0]  fwd_idx;
    logic              stall_c;

    always_comb begin
        imm_sel = ex_imm && (ex_alu_op != OP_IMM_ELSEWHERE_A) && (ex_alu_op != OP_IMM_ELSEWHERE_B);
        for (int k = 0; k < STAGES; k++) begin
            match[k] = tag_valid_q[k] && (tag_addr_q[k] == ex_src_addr) && ex_valid && ex_src_used;
        end
        stall_c = match[0] && tag_load_q[0] && !in_port_sig && !imm_sel;
    end

    // Scan oldest to youngest so the lowest matching slice is the one left standing.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_idx = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (match[k]) begin
                fwd_hit = 1'b1;
                fwd_idx = STG_W'(k);
            end
        end
    end

    always_comb begin
        operand   = rf_data;
        src_kind  = KIND_RF;
        fwd_stage = '0;
        if (in_port_sig) begin
            operand  = in_port_data;
            src_kind = KIND_PORT;
        end else if (imm_sel) begin
            operand  = immediate;
            src_kind = KIND_IMM;
        end else if (stall_c) begin
            operand  = rf_data;
            src_kind = KIND_RF;
        end else if (fwd_hit) begin
            operand   = stage_data[fwd_idx*DATA_W +: DATA_W];
            src_kind  = KIND_FWD;
            fwd_stage = fwd_idx;
        end
    end

    always_comb begin
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (src_kind == KIND_FWD && fwd_cnt_q != 16'hFFFF) begin
            fwd_cnt_d = fwd_cnt_q + 16'd1;
        end
        if (stall_c && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= '0;
            tag_load_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                tag_addr_q[k] <= '0;
            end
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (!pipe_hold) begin
            // A stalled EX instruction is re-presented next cycle, so a bubble enters here.
            tag_valid_q[0] <= stall_c ? 1'b0 : (ex_valid && ex_wb_en);
            tag_load_q[0]  <= stall_c ? 1'b0 : ex_is_load;
            tag_addr_q[0]  <= ex_dst_addr;
            for (int k = 1; k < STAGES; k++) begin
                tag_valid_q[k] <= tag_valid_q[k-1];
                tag_load_q[k]  <= tag_load_q[k-1];
                tag_addr_q[k]  <= tag_addr_q[k-1];
            end
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall     = stall_c;
    assign fwd_cnt   = fwd_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_forward_unit.sv
// Bench for operand_forward_unit: directed test-plan steps, then random traffic,
// all checked against a history-queue reference model.
module tb_operand_forward_unit;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int STAGES   = 2;
    localparam int ALU_OP_W = 4;
    localparam int STG_W    = 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     pipe_hold;
    logic                     ex_valid;
    logic                     ex_src_used;
    logic [ADDR_W-1:0]        ex_src_addr;
    logic [ADDR_W-1:0]        ex_dst_addr;
    logic                     ex_wb_en;
    logic                     ex_is_load;
    logic                     ex_imm;
    logic [ALU_OP_W-1:0]      ex_alu_op;
    logic [DATA_W-1:0]        immediate;
    logic                     in_port_sig;
    logic [DATA_W-1:0]        in_port_data;
    logic [DATA_W-1:0]        rf_data;
    logic [STAGES*DATA_W-1:0] stage_data;
    logic [DATA_W-1:0]        operand;
    logic [1:0]               src_kind;
    logic [STG_W-1:0]         fwd_stage;
    logic                     stall;
    logic [15:0]              fwd_cnt;
    logic [15:0]              stall_cnt;

    operand_forward_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAGES(STAGES), .ALU_OP_W(ALU_OP_W), .STG_W(STG_W)
    ) dut (
        .clk(clk), .rst(rst), .pipe_hold(pipe_hold),
        .ex_valid(ex_valid), .ex_src_used(ex_src_used), .ex_src_addr(ex_src_addr),
        .ex_dst_addr(ex_dst_addr), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
        .ex_imm(ex_imm), .ex_alu_op(ex_alu_op), .immediate(immediate),
        .in_port_sig(in_port_sig), .in_port_data(in_port_data), .rf_data(rf_data),
        .stage_data(stage_data), .operand(operand), .src_kind(src_kind),
        .fwd_stage(fwd_stage), .stall(stall), .fwd_cnt(fwd_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: hist[k] is the k-th most recent instruction that left EX.
    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] addr;
        logic              ld;
    } ent_t;

    ent_t        hist[$];
    int unsigned exp_fwd_cnt;
    int unsigned exp_stall_cnt;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        ent_t e;
        e = '0;
        hist.delete();
        for (int k = 0; k < STAGES; k++) hist.push_back(e);
        exp_fwd_cnt   = 0;
        exp_stall_cnt = 0;
    endtask

    task automatic idle();
        rst = 0; pipe_hold = 0; ex_valid = 0; ex_src_used = 0; ex_src_addr = '0;
        ex_dst_addr = '0; ex_wb_en = 0; ex_is_load = 0; ex_imm = 0; ex_alu_op = '0;
        immediate = 16'h1111; in_port_sig = 0; in_port_data = 16'h2222;
        rf_data = 16'h3333; stage_data = {16'h5555, 16'h4444};
    endtask

    task automatic issue(input logic [ADDR_W-1:0] dst, input logic ld,
                         input logic used, input logic [ADDR_W-1:0] src);
        ex_valid = 1; ex_wb_en = 1; ex_dst_addr = dst; ex_is_load = ld;
        ex_src_used = used; ex_src_addr = src;
    endtask

    // Called at a negedge with inputs applied; checks this cycle, advances one clock.
    task automatic step();
        logic              imm_sel, m_stall;
        int                fk;
        logic [DATA_W-1:0] e_op;
        logic [1:0]        e_kind;
        int                e_stg;
        ent_t              e;
        #1;
        imm_sel = ex_imm && (ex_alu_op != 4'hB) && (ex_alu_op != 4'hC);
        fk = -1;
        for (int k = 0; k < STAGES; k++) begin
            if (fk < 0 && ex_valid && ex_src_used && hist[k].v && hist[k].addr == ex_src_addr) fk = k;
        end
        m_stall = (fk == 0) && hist[0].ld && !in_port_sig && !imm_sel;
        e_stg = 0;
        if (in_port_sig) begin
            e_op = in_port_data; e_kind = 2'b11;
        end else if (imm_sel) begin
            e_op = immediate; e_kind = 2'b10;
        end else if (m_stall) begin
            e_op = rf_data; e_kind = 2'b00;
        end else if (fk >= 0) begin
            e_op = stage_data[fk*DATA_W +: DATA_W]; e_kind = 2'b01; e_stg = fk;
        end else begin
            e_op = rf_data; e_kind = 2'b00;
        end
        chk("operand", 32'(operand), 32'(e_op));
        chk("src_kind", 32'(src_kind), 32'(e_kind));
        chk("fwd_stage", 32'(fwd_stage), 32'(e_stg));
        chk("stall", 32'(stall), 32'(m_stall));
        chk("fwd_cnt", 32'(fwd_cnt), exp_fwd_cnt);
        chk("stall_cnt", 32'(stall_cnt), exp_stall_cnt);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (!pipe_hold) begin
            if (e_kind == 2'b01 && exp_fwd_cnt < 65535) exp_fwd_cnt++;
            if (m_stall && exp_stall_cnt < 65535) exp_stall_cnt++;
            e.v    = m_stall ? 1'b0 : (ex_valid && ex_wb_en);
            e.addr = ex_dst_addr;
            e.ld   = ex_is_load;
            hist.push_front(e);
            void'(hist.pop_back());
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
        #1;
        chk("reset_fwd_cnt", 32'(fwd_cnt), 32'h0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("reset_kind", 32'(src_kind), 32'h0);
        step();

        // Back-to-back forward
        issue(3'd2, 0, 0, 3'd0); step();
        issue(3'd6, 0, 1, 3'd2); stage_data[15:0] = 16'h1234;
        #1 chk("b2b_operand", 32'(operand), 32'h1234);
        chk("b2b_stage", 32'(fwd_stage), 32'h0);
        step();
        idle(); #1 chk("b2b_cnt", 32'(fwd_cnt), 32'h1);
        step();

        // One-instruction gap
        issue(3'd5, 0, 0, 3'd0); step();
        issue(3'd7, 0, 0, 3'd0); step();
        issue(3'd0, 0, 1, 3'd5); stage_data = {16'hBEEF, 16'h0000};
        #1 chk("gap_operand", 32'(operand), 32'hBEEF);
        chk("gap_stage", 32'(fwd_stage), 32'h1);
        step();

        // Youngest wins
        issue(3'd3, 0, 0, 3'd0); step();
        issue(3'd3, 0, 0, 3'd0); step();
        issue(3'd1, 0, 1, 3'd3); stage_data = {16'h0002, 16'h0001};
        #1 chk("young_operand", 32'(operand), 32'h0001);
        step();

        // Load-use: one stall cycle, then slice 1
        idle(); step();
        issue(3'd4, 1, 0, 3'd0); step();
        issue(3'd1, 0, 1, 3'd4);
        #1 chk("lu_stall", 32'(stall), 32'h1);
        step();
        stage_data = {16'h00AA, 16'h0000};
        #1 chk("lu_operand", 32'(operand), 32'h00AA);
        chk("lu_stall_after", 32'(stall), 32'h0);
        chk("lu_stage", 32'(fwd_stage), 32'h1);
        step();

        // Stall under pipe_hold: stays high, no count
        idle(); step();
        issue(3'd4, 1, 0, 3'd0); step();
        issue(3'd1, 0, 1, 3'd4); pipe_hold = 1;
        step(); step();
        #1 chk("hold_stall", 32'(stall), 32'h1);
        pipe_hold = 0;
        step(); step();

        // Overrides
        idle(); issue(3'd2, 0, 0, 3'd0); step();
        issue(3'd0, 0, 1, 3'd2); in_port_sig = 1; in_port_data = 16'hCAFE;
        #1 chk("port_operand", 32'(operand), 32'hCAFE);
        chk("port_kind", 32'(src_kind), 32'h3);
        step();
        idle(); issue(3'd2, 0, 0, 3'd0); step();
        issue(3'd0, 0, 1, 3'd2); ex_imm = 1; ex_alu_op = 4'b1011; stage_data[15:0] = 16'h7777;
        #1 chk("op1011_operand", 32'(operand), 32'h7777);
        step();
        idle(); issue(3'd2, 0, 0, 3'd0); step();
        issue(3'd0, 0, 1, 3'd2); ex_imm = 1; ex_alu_op = 4'b0001; immediate = 16'h0F0F;
        #1 chk("imm_operand", 32'(operand), 32'h0F0F);
        step();

        // Reset mid-stall
        idle(); issue(3'd4, 1, 0, 3'd0); step();
        issue(3'd1, 0, 1, 3'd4); rst = 1;
        step();
        rst = 0;
        #1 chk("rst_kind", 32'(src_kind), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_fwd_cnt", 32'(fwd_cnt), 32'h0);
        step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 59) == 0);
            pipe_hold    = ($urandom_range(0, 7) == 0);
            ex_valid     = ($urandom_range(0, 5) != 0);
            ex_src_used  = ($urandom_range(0, 4) != 0);
            ex_src_addr  = ADDR_W'($urandom_range(0, 3));
            ex_dst_addr  = ADDR_W'($urandom_range(0, 3));
            ex_wb_en     = ($urandom_range(0, 3) != 0);
            ex_is_load   = ($urandom_range(0, 2) == 0);
            ex_imm       = ($urandom_range(0, 3) == 0);
            ex_alu_op    = ALU_OP_W'($urandom_range(0, 15));
            immediate    = DATA_W'($urandom);
            in_port_sig  = ($urandom_range(0, 7) == 0);
            in_port_data = DATA_W'($urandom);
            rf_data      = DATA_W'($urandom);
            stage_data   = (STAGES*DATA_W)'($urandom);
            step();
        end

        // Forward counter saturation
        idle();
        issue(3'd1, 0, 1, 3'd1);
        for (int i = 0; i < 65540; i++) step();
        #1 chk("sat_fwd_cnt", 32'(fwd_cnt), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
